mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of EX and upstream of WB.
//  - Latches EX outputs into the MEM pipeline register.
//  - Aligns and extends load data from data_sram_rdata (valid one cycle after the EX request).
//  - Selects mul, load or ALU/div result and forwards it to WB.
//  - Publishes a bypass bus for ID hazard resolution.
//  - Holds rdata and mul_result that arrive only in the first MEM cycle when WB stalls.
// PARAMETERS
//  EXTRA_W  82  width of opaque WB payload {has_sys, ertn_flush, csr_ctrl[79:0]}, passed through untouched
// PORTS
//  clk              in   1   system clock
//  reset            in   1   asynchronous, active-high reset
//  ex_valid         in   1   EX holds a valid instruction
//  ex_ready_go      in   1   EX result complete (div done)
//  mem_allow_in     out  1   MEM can accept from EX this cycle
//  ex_result        in   32  ALU/div result; for ld/st, the byte address
//  ex_mul           in   1   instruction is a multiply
//  ex_mul_result    in   32  multiplier output, valid only in the instruction's first MEM cycle
//  ex_ld_ctrl       in   5   {ld_w, ld_hu, ld_h, ld_bu, ld_b}, one-hot or zero
//  ex_res_from_mem  in   1   result comes from load data
//  ex_res_from_csr  in   1   result comes from CSR (resolved in WB)
//  ex_rf_we         in   1   register-file write enable
//  ex_rf_waddr      in   5   destination register
//  ex_pc            in   32  instruction PC
//  ex_extra         in   EXTRA_W  opaque WB payload
//  data_sram_rdata  in   32  SRAM read data for the request issued in the previous cycle
//  flush            in   1   exception/ertn flush from WB
//  wb_allow_in      in   1   WB can accept this cycle
//  mem_ready_go     out  1   always 1; stalls come only from wb_allow_in
//  memreg_valid     out  1   MEM → WB valid (= mem_valid)
//  mem_result       out  32  final result
//  mem_rf_we / mem_rf_waddr / mem_res_from_csr / mem_pc / mem_extra  out  registered copies
//  byp_rf_we        out  1   mem_valid & mem_rf_we
//  byp_rf_waddr     out  5   mem_rf_waddr
//  byp_res_from_csr out  1   consumer must stall (value not yet known)
//  byp_result       out  32  = mem_result
// BEHAVIOUR
//  - Reset (async): mem_valid=0, first=0, hold_v=0; all latched fields and hold_data = 0.
//    Hence memreg_valid=0, byp_rf_we=0, mem_result=0.
//  - mem_allow_in = ~mem_valid | (mem_ready_go & wb_allow_in).
//  - Posedge priority:
//    - flush: mem_valid<=0, first<=0, hold_v<=0.
//    - else if mem_allow_in: mem_valid<=ex_valid&ex_ready_go; first<=same. Fields latch when ex_valid&ex_ready_go.
//    - else (stalled): first<=0.
//      - If first=1, hold_data<=raw_sel and hold_v<=1.
//  - raw_sel = mem_mul ? ex_mul_result : data_sram_rdata.
//  - raw = hold_v ? hold_data : raw_sel.
//  - hold_v clears whenever a new instruction is latched or on flush.
//  - Load align, using a = mem_result_addr[1:0]:
//    - ld_b / ld_bu: byte a, sign / zero extended.
//    - ld_h / ld_hu: halfword a[1] (a[0] ignored), sign / zero extended.
//    - ld_w: full word.
//  - mem_result = res_from_mem ? load_data : mem_mul ? raw : latched ex_result.
//  - mem_ready_go = 1; no internal wait states.
//  - Simultaneous flush and EX hand-off: flush wins, and the instruction is dropped.
//  - Reset mid-stall discards the held data.
// TESTING
//  1. ld_b, addr 0x...3, rdata 0x80FF_1234, wb_allow_in=1 -> mem_result 0xFFFF_FF80; ld_bu -> 0x0000_0080.
//  2. ld_h, addr 0x...2, rdata 0x8001_7FFF -> 0xFFFF_8001; ld_hu addr 0x...0 -> 0x0000_7FFF.
//  3. ld_w, wb_allow_in=0 for 3 cycles, rdata 0xDEAD_BEEF then 0x0 -> mem_result stays 0xDEAD_BEEF; mem_allow_in=0 until WB accepts.
//  4. mul, ex_mul_result 0x0000_0042 first cycle then 0x0 with WB stall -> mem_result 0x42 throughout.
//  5. flush asserted with ex_valid=1 and mem_allow_in=1 -> next cycle memreg_valid=0, byp_rf_we=0.
//  6. Reset asserted mid-stall (async, no clock edge) -> memreg_valid=0 immediately; after release, first load uses fresh rdata.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX results, aligns load data, selects the final result and drives the ID bypass bus.
// Zero-latency result path; holds first-cycle SRAM/mul data while WB stalls.
module mem_stage #(
   parameter int EXTRA_W = 82
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ex_valid,
   input  logic               ex_ready_go,
   output logic               mem_allow_in,
   input  logic [31:0]        ex_result,
   input  logic               ex_mul,
   input  logic [31:0]        ex_mul_result,
   input  logic [4:0]         ex_ld_ctrl,
   input  logic               ex_res_from_mem,
   input  logic               ex_res_from_csr,
   input  logic               ex_rf_we,
   input  logic [4:0]         ex_rf_waddr,
   input  logic [31:0]        ex_pc,
   input  logic [EXTRA_W-1:0] ex_extra,
   input  logic [31:0]        data_sram_rdata,
   input  logic               flush,
   input  logic               wb_allow_in,
   output logic               mem_ready_go,
   output logic               memreg_valid,
   output logic [31:0]        mem_result,
   output logic               mem_rf_we,
   output logic [4:0]         mem_rf_waddr,
   output logic               mem_res_from_csr,
   output logic [31:0]        mem_pc,
   output logic [EXTRA_W-1:0] mem_extra,
   output logic               byp_rf_we,
   output logic [4:0]         byp_rf_waddr,
   output logic               byp_res_from_csr,
   output logic [31:0]        byp_result
);

   logic               valid_q, valid_d;
   logic               first_q, first_d;
   logic               hold_v_q, hold_v_d;
   logic [31:0]        hold_data_q, hold_data_d;
   logic [31:0]        result_q;
   logic               mul_q;
   logic [4:0]         ld_ctrl_q;
   logic               res_from_mem_q;
   logic               res_from_csr_q;
   logic               rf_we_q;
   logic [4:0]         rf_waddr_q;
   logic [31:0]        pc_q;
   logic [EXTRA_W-1:0] extra_q;

   logic        ex_fire;
   logic        load_en;
   logic [31:0] raw_sel;
   logic [31:0] raw;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   assign mem_ready_go = 1'b1;
   assign mem_allow_in = ~valid_q | (mem_ready_go & wb_allow_in);
   assign ex_fire      = ex_valid & ex_ready_go;
   assign load_en      = ~flush & mem_allow_in & ex_fire;

   // SRAM data and mul output only exist in the first MEM cycle; later cycles read the held copy.
   assign raw_sel = mul_q ? ex_mul_result : data_sram_rdata;
   assign raw     = hold_v_q ? hold_data_q : raw_sel;

   always_comb begin
      valid_d     = valid_q;
      first_d     = first_q;
      hold_v_d    = hold_v_q;
      hold_data_d = hold_data_q;
      if (flush) begin
         valid_d  = 1'b0;
         first_d  = 1'b0;
         hold_v_d = 1'b0;
      end else if (mem_allow_in) begin
         valid_d  = ex_fire;
         first_d  = ex_fire;
         hold_v_d = 1'b0;
      end else begin
         first_d = 1'b0;
         if (first_q) begin
            hold_data_d = raw_sel;
            hold_v_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         hold_v_q    <= 1'b0;
         hold_data_q <= '0;
      end else begin
         valid_q     <= valid_d;
         first_q     <= first_d;
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q       <= '0;
         mul_q          <= 1'b0;
         ld_ctrl_q      <= '0;
         res_from_mem_q <= 1'b0;
         res_from_csr_q <= 1'b0;
         rf_we_q        <= 1'b0;
         rf_waddr_q     <= '0;
         pc_q           <= '0;
         extra_q        <= '0;
      end else if (load_en) begin
         result_q       <= ex_result;
         mul_q          <= ex_mul;
         ld_ctrl_q      <= ex_ld_ctrl;
         res_from_mem_q <= ex_res_from_mem;
         res_from_csr_q <= ex_res_from_csr;
         rf_we_q        <= ex_rf_we;
         rf_waddr_q     <= ex_rf_waddr;
         pc_q           <= ex_pc;
         extra_q        <= ex_extra;
      end
   end

   // Byte lane from the low address bits; halfword lane ignores bit 0.
   always_comb begin
      ld_byte = raw[7:0];
      case (result_q[1:0])
         2'd0:    ld_byte = raw[7:0];
         2'd1:    ld_byte = raw[15:8];
         2'd2:    ld_byte = raw[23:16];
         default: ld_byte = raw[31:24];
      endcase
   end

   assign ld_half = result_q[1] ? raw[31:16] : raw[15:0];

   always_comb begin
      load_data = raw;
      if (ld_ctrl_q[0])      load_data = {{24{ld_byte[7]}}, ld_byte};
      else if (ld_ctrl_q[1]) load_data = {24'd0, ld_byte};
      else if (ld_ctrl_q[2]) load_data = {{16{ld_half[15]}}, ld_half};
      else if (ld_ctrl_q[3]) load_data = {16'd0, ld_half};
      else if (ld_ctrl_q[4]) load_data = raw;
   end

   assign mem_result = res_from_mem_q ? load_data : (mul_q ? raw : result_q);

   assign memreg_valid     = valid_q;
   assign mem_rf_we        = rf_we_q;
   assign mem_rf_waddr     = rf_waddr_q;
   assign mem_res_from_csr = res_from_csr_q;
   assign mem_pc           = pc_q;
   assign mem_extra        = extra_q;

   assign byp_rf_we        = valid_q & rf_we_q;
   assign byp_rf_waddr     = rf_waddr_q;
   assign byp_res_from_csr = valid_q & res_from_csr_q;
   assign byp_result       = mem_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a stimulus process pushes expected results, a negedge monitor pops and compares.
module tb_mem_stage;

   localparam int EXTRA_W = 82;

   logic               clk = 1'b0;
   logic               reset;
   logic               ex_valid, ex_ready_go, mem_allow_in;
   logic [31:0]        ex_result;
   logic               ex_mul;
   logic [31:0]        ex_mul_result;
   logic [4:0]         ex_ld_ctrl;
   logic               ex_res_from_mem, ex_res_from_csr, ex_rf_we;
   logic [4:0]         ex_rf_waddr;
   logic [31:0]        ex_pc;
   logic [EXTRA_W-1:0] ex_extra;
   logic [31:0]        data_sram_rdata;
   logic               flush, wb_allow_in, mem_ready_go, memreg_valid;
   logic [31:0]        mem_result;
   logic               mem_rf_we;
   logic [4:0]         mem_rf_waddr;
   logic               mem_res_from_csr;
   logic [31:0]        mem_pc;
   logic [EXTRA_W-1:0] mem_extra;
   logic               byp_rf_we;
   logic [4:0]         byp_rf_waddr;
   logic               byp_res_from_csr;
   logic [31:0]        byp_result;

   typedef struct {
      logic [31:0]        result;
      logic [31:0]        pc;
      logic [4:0]         waddr;
      logic [EXTRA_W-1:0] extra;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc_ctr   = 32'h1C00_0000;

   localparam logic [4:0] LD_B  = 5'b00001;
   localparam logic [4:0] LD_BU = 5'b00010;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b01000;
   localparam logic [4:0] LD_W  = 5'b10000;

   always #5 clk = ~clk;

   mem_stage #(.EXTRA_W(EXTRA_W)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready_go(ex_ready_go), .mem_allow_in(mem_allow_in),
      .ex_result(ex_result), .ex_mul(ex_mul), .ex_mul_result(ex_mul_result),
      .ex_ld_ctrl(ex_ld_ctrl), .ex_res_from_mem(ex_res_from_mem),
      .ex_res_from_csr(ex_res_from_csr), .ex_rf_we(ex_rf_we),
      .ex_rf_waddr(ex_rf_waddr), .ex_pc(ex_pc), .ex_extra(ex_extra),
      .data_sram_rdata(data_sram_rdata), .flush(flush), .wb_allow_in(wb_allow_in),
      .mem_ready_go(mem_ready_go), .memreg_valid(memreg_valid), .mem_result(mem_result),
      .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
      .mem_res_from_csr(mem_res_from_csr), .mem_pc(mem_pc), .mem_extra(mem_extra),
      .byp_rf_we(byp_rf_we), .byp_rf_waddr(byp_rf_waddr),
      .byp_res_from_csr(byp_res_from_csr), .byp_result(byp_result)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every valid MEM cycle must show the head of the scoreboard; pop on WB handshake.
   always @(negedge clk) begin
      if (!reset && memreg_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 128'(memreg_valid), 128'd0);
         end else begin
            check("mem_result", 128'(mem_result), 128'(sb[0].result));
            check("byp_result", 128'(byp_result), 128'(sb[0].result));
            check("mem_pc", 128'(mem_pc), 128'(sb[0].pc));
            check("byp_rf_waddr", 128'(byp_rf_waddr), 128'(sb[0].waddr));
            check("byp_rf_we", 128'(byp_rf_we), 128'd1);
            check("mem_extra", 128'(mem_extra), 128'(sb[0].extra));
            if (wb_allow_in) void'(sb.pop_front());
         end
      end
   end

   // Drives one instruction into MEM and leaves it in its first MEM cycle.
   task automatic start(input logic [4:0] ctrl, input logic mul, input logic [31:0] res,
                        input logic [31:0] rdata, input int stall, input logic [31:0] expv);
      exp_t e;
      pc_ctr          += 32'd4;
      ex_result       = res;
      ex_mul          = mul;
      ex_ld_ctrl      = ctrl;
      ex_res_from_mem = (ctrl != 5'd0);
      ex_res_from_csr = 1'b0;
      ex_rf_we        = 1'b1;
      ex_rf_waddr     = pc_ctr[6:2];
      ex_pc           = pc_ctr;
      ex_extra        = {pc_ctr, ~pc_ctr, 18'h2_5A3C};
      ex_valid        = 1'b1;
      ex_ready_go     = 1'b1;
      wb_allow_in     = (stall == 0);
      e.result = expv;
      e.pc     = pc_ctr;
      e.waddr  = pc_ctr[6:2];
      e.extra  = {pc_ctr, ~pc_ctr, 18'h2_5A3C};
      sb.push_back(e);
      @(posedge clk); #1;
      ex_valid        = 1'b0;
      data_sram_rdata = mul ? ~rdata : rdata;
      ex_mul_result   = mul ? rdata : ~rdata;
   endtask

   task automatic issue(input logic [4:0] ctrl, input logic mul, input logic [31:0] res,
                        input logic [31:0] rdata, input int stall, input logic [31:0] expv);
      start(ctrl, mul, res, rdata, stall, expv);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         data_sram_rdata = 32'd0;
         ex_mul_result   = 32'd0;
         check("allow_in_stall", 128'(mem_allow_in), 128'd0);
      end
      wb_allow_in = 1'b1;
      @(posedge clk); #1;
      data_sram_rdata = 32'd0;
      ex_mul_result   = 32'd0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; wb_allow_in = 1'b1;
      ex_valid = 1'b0; ex_ready_go = 1'b0; ex_result = '0; ex_mul = 1'b0;
      ex_mul_result = '0; ex_ld_ctrl = '0; ex_res_from_mem = 1'b0; ex_res_from_csr = 1'b0;
      ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_pc = '0; ex_extra = '0; data_sram_rdata = '0;
      #2;
      check("rst_memreg_valid", 128'(memreg_valid), 128'd0);
      check("rst_byp_rf_we", 128'(byp_rf_we), 128'd0);
      check("rst_mem_result", 128'(mem_result), 128'd0);
      check("rst_allow_in", 128'(mem_allow_in), 128'd1);
      check("rst_ready_go", 128'(mem_ready_go), 128'd1);
      @(posedge clk); #1;
      reset = 1'b0;

      issue(LD_B,  1'b0, 32'h0000_1003, 32'h80FF_1234, 0, 32'hFFFF_FF80);
      issue(LD_BU, 1'b0, 32'h0000_1003, 32'h80FF_1234, 0, 32'h0000_0080);
      issue(LD_B,  1'b0, 32'h0000_1001, 32'h80FF_1234, 0, 32'h0000_0012);
      issue(LD_H,  1'b0, 32'h0000_2002, 32'h8001_7FFF, 0, 32'hFFFF_8001);
      issue(LD_HU, 1'b0, 32'h0000_2000, 32'h8001_7FFF, 0, 32'h0000_7FFF);
      issue(LD_H,  1'b0, 32'h0000_2003, 32'h8001_7FFF, 0, 32'hFFFF_8001);
      issue(LD_W,  1'b0, 32'h0000_3000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
      issue(5'd0,  1'b1, 32'h0000_0007, 32'h0000_0042, 3, 32'h0000_0042);
      issue(5'd0,  1'b0, 32'h1234_5678, 32'h0BAD_0BAD, 1, 32'h1234_5678);
      issue(LD_BU, 1'b0, 32'h0000_4002, 32'h00A5_0000, 2, 32'h0000_00A5);

      // flush beats a simultaneous EX hand-off
      ex_valid = 1'b1; ex_ready_go = 1'b1; ex_rf_we = 1'b1; flush = 1'b1; wb_allow_in = 1'b1;
      check("flush_allow_in", 128'(mem_allow_in), 128'd1);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      check("flush_memreg_valid", 128'(memreg_valid), 128'd0);
      check("flush_byp_rf_we", 128'(byp_rf_we), 128'd0);
      @(posedge clk); #1;

      // async reset in the middle of a WB stall
      start(LD_W, 1'b0, 32'h0000_5000, 32'h1111_1111, 2, 32'h1111_1111);
      @(posedge clk); #1;
      data_sram_rdata = 32'd0;
      #2;
      sb.delete();
      reset = 1'b1;
      #1;
      check("midstall_rst_valid", 128'(memreg_valid), 128'd0);
      check("midstall_rst_byp_we", 128'(byp_rf_we), 128'd0);
      check("midstall_rst_result", 128'(mem_result), 128'd0);
      @(posedge clk); #1;
      reset = 1'b0; wb_allow_in = 1'b1;
      issue(LD_W, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      check("scoreboard_drained", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
